// File: rtl/vending_machine_pkg.sv
// Shared types for the two-product vending controller: coin codes,
// FSM states and the coin-code-to-value decode.
package vending_machine_pkg;

    localparam logic [1:0] C0 = 2'b00;
    localparam logic [1:0] C1 = 2'b01;
    localparam logic [1:0] C2 = 2'b10;
    localparam logic [1:0] C5 = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2
    } state_e;

    function automatic logic [3:0] coin_val(input logic [1:0] code);
        logic [3:0] v;
        case (code)
            C1:      v = 4'd1;
            C2:      v = 4'd2;
            C5:      v = 4'd5;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vending_machine_coin_detect.sv
// New-coin edge detector: a coin code counts only on the cycle it
// first differs from the previous cycle's code.
module coin_detect
    import vending_machine_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin,
    output logic       coin_valid,
    output logic [3:0] coin_value
);

    logic [1:0] prev_coin_q;

    always_ff @(posedge clk) begin
        if (rst) prev_coin_q <= C0;
        else     prev_coin_q <= coin;
    end

    assign coin_valid = (coin != C0) && (coin != prev_coin_q);
    assign coin_value = coin_val(coin);

endmodule

// File: rtl/vending_machine.sv
// Vending controller FSM (IDLE/COLLECT/VEND) with credit and output regs.
// Optional refund on start deassert: VENDING_MACHINE_REFUND_EN.
module vending_machine
    import vending_machine_pkg::*;
#(
    parameter int unsigned PRICE_DRINK = 4,
    parameter int unsigned PRICE_CHOC  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] coin,
    input  logic       select_line,
    output logic       product,
    output logic [3:0] change,
    output logic       done
);

    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       product_q, product_d;
    logic       done_q, done_d;
    logic [3:0] change_q, change_d;

    logic       coin_valid;
    logic [3:0] coin_value;
    logic       accept;
    logic [4:0] sum;
    logic [3:0] credit_next;
    logic [3:0] price;
    logic       hit;

    coin_detect u_coin_detect (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin),
        .coin_valid (coin_valid),
        .coin_value (coin_value)
    );

    // Saturating add: an overflowing credit is clamped and always vends.
    assign accept      = (state_q == COLLECT) && coin_valid;
    assign sum         = {1'b0, credit_q} + (accept ? {1'b0, coin_value} : 5'd0);
    assign credit_next = sum[4] ? 4'hF : sum[3:0];
    assign price       = select_line ? 4'(PRICE_DRINK) : 4'(PRICE_CHOC);
    assign hit         = (credit_next >= price);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            credit_q  <= 4'd0;
            product_q <= 1'b0;
            done_q    <= 1'b0;
            change_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            product_q <= product_d;
            done_q    <= done_d;
            change_q  <= change_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                credit_d = 4'd0;
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                if (hit) begin
                    state_d  = VEND;
                    credit_d = 4'd0;
                end
`ifdef VENDING_MACHINE_REFUND_EN
                else if (!start) begin
                    state_d  = (credit_q != 4'd0) ? VEND : IDLE;
                    credit_d = 4'd0;
                end
`endif
                else begin
                    credit_d = credit_next;
                end
            end
            VEND: begin
                state_d  = IDLE;
                credit_d = 4'd0;
            end
            default: begin
                state_d  = IDLE;
                credit_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        product_d = 1'b0;
        done_d    = 1'b0;
        change_d  = 4'd0;
        if (state_q == COLLECT) begin
            if (hit) begin
                product_d = 1'b1;
                done_d    = 1'b1;
                change_d  = credit_next - price;
            end
`ifdef VENDING_MACHINE_REFUND_EN
            else if (!start && credit_q != 4'd0) begin
                done_d   = 1'b1;
                change_d = credit_q;
            end
`endif
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign change  = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine against a transaction-level
// credit model; honours VENDING_MACHINE_REFUND_EN when defined.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       select_line = 1'b0;
    logic       product;
    logic [3:0] change;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit collecting;
    bit vending;
    int credit;
    int prev;
    bit e_prod;
    bit e_done;
    int e_chg;

    vending_machine #(.PRICE_DRINK(4), .PRICE_CHOC(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .coin        (coin),
        .select_line (select_line),
        .product     (product),
        .change      (change),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic int value_of(input int code);
        int tbl[4] = '{0, 1, 2, 5};
        return tbl[code];
    endfunction

    // One clock edge of the customer-visible rules, in plain arithmetic.
    task automatic model_edge();
        int got;
        int price;
        e_prod = 0;
        e_done = 0;
        e_chg  = 0;
        if (rst) begin
            collecting = 0;
            vending    = 0;
            credit     = 0;
            prev       = 0;
            return;
        end
        got = (collecting && coin != 0 && int'(coin) != prev) ? value_of(coin) : 0;
        price = select_line ? 4 : 3;
        if (vending) begin
            vending = 0;
        end else if (collecting) begin
            if (credit + got > 15) got = 15 - credit;
            if (credit + got >= price) begin
                e_prod = 1;
                e_done = 1;
                e_chg  = credit + got - price;
                credit = 0;
                collecting = 0;
                vending = 1;
            end
`ifdef VENDING_MACHINE_REFUND_EN
            else if (!start) begin
                if (credit > 0) begin
                    e_done  = 1;
                    e_chg   = credit;
                    vending = 1;
                end
                credit = 0;
                collecting = 0;
            end
`endif
            else begin
                credit += got;
            end
        end else if (start) begin
            collecting = 1;
        end
        prev = coin;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        coin = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({product, done, change} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset: got p=%0b d=%0b c=%0d want 0 0 0", product, done, change);
        end
        n_checks++;
        coin = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            if (product !== 1'b0 || done !== 1'b0 || change !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_coin: got p=%0b d=%0b c=%0d want 0 0 0", product, done, change);
            end
            n_checks++;
        end
    endtask

    task automatic test_drink5();
        int pulses = 0;
        do_reset();
        start = 1'b1;
        select_line = 1'b1;
        step();
        coin = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) pulses++;
            if (product !== e_prod || done !== e_done || change !== 4'(e_chg)) begin
                n_fail++;
                $display("FAIL drink5: got p=%0b d=%0b c=%0d want p=%0b d=%0b c=%0d",
                         product, done, change, e_prod, e_done, e_chg);
            end
            n_checks++;
            if (i == 0 && (product !== 1'b1 || change !== 4'd1)) begin
                n_fail++;
                $display("FAIL drink5_first: got p=%0b c=%0d want p=1 c=1", product, change);
            end
            if (i == 0) n_checks++;
        end
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL drink5_pulses: got %0d want 1", pulses);
        end
        n_checks++;
    endtask

    task automatic test_choc_1_2();
        logic [1:0] seq[3] = '{2'b01, 2'b00, 2'b10};
        do_reset();
        start = 1'b1;
        select_line = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            coin = seq[i];
            step();
            if (product !== e_prod || done !== e_done || change !== 4'(e_chg)) begin
                n_fail++;
                $display("FAIL choc12: got p=%0b d=%0b c=%0d want p=%0b d=%0b c=%0d",
                         product, done, change, e_prod, e_done, e_chg);
            end
            n_checks++;
        end
        if (product !== 1'b1 || change !== 4'd0) begin
            n_fail++;
            $display("FAIL choc12_vend: got p=%0b c=%0d want p=1 c=0", product, change);
        end
        n_checks++;
    endtask

    task automatic test_select_switch();
        logic [1:0] seq[3] = '{2'b01, 2'b00, 2'b10};
        do_reset();
        start = 1'b1;
        select_line = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            coin = seq[i];
            step();
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL select_novend: got d=%0b want d=0", done);
            end
            n_checks++;
        end
        select_line = 1'b0;
        step();
        if (product !== 1'b1 || done !== 1'b1 || change !== 4'd0) begin
            n_fail++;
            $display("FAIL select_vend: got p=%0b d=%0b c=%0d want 1 1 0", product, done, change);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq[8] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        int vends = 0;
        do_reset();
        start = 1'b1;
        select_line = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            coin = seq[i];
            step();
            if (done) vends++;
            if (product !== e_prod || done !== e_done || change !== 4'(e_chg)) begin
                n_fail++;
                $display("FAIL b2b: got p=%0b d=%0b c=%0d want p=%0b d=%0b c=%0d",
                         product, done, change, e_prod, e_done, e_chg);
            end
            n_checks++;
        end
        if (vends !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", vends);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq[5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        do_reset();
        start = 1'b1;
        select_line = 1'b1;
        step();
        coin = 2'b10;
        step();
        coin = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (done !== 1'b0 || change !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got d=%0b c=%0d want 0 0", done, change);
        end
        n_checks++;
        step();
        for (int i = 0; i < 5; i++) begin
            coin = seq[i];
            step();
            if (product !== e_prod || done !== e_done || change !== 4'(e_chg)) begin
                n_fail++;
                $display("FAIL rst_mid_after: got p=%0b d=%0b c=%0d want p=%0b d=%0b c=%0d",
                         product, done, change, e_prod, e_done, e_chg);
            end
            n_checks++;
        end
    endtask

    task automatic test_refund();
        logic [1:0] seq[5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        do_reset();
        start = 1'b1;
        select_line = 1'b0;
        step();
        coin = 2'b10;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            coin = seq[i];
            step();
            if (product !== e_prod || done !== e_done || change !== 4'(e_chg)) begin
                n_fail++;
                $display("FAIL refund: got p=%0b d=%0b c=%0d want p=%0b d=%0b c=%0d",
                         product, done, change, e_prod, e_done, e_chg);
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) != 0);
            coin = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) select_line = ~select_line;
            step();
            if (product !== e_prod || done !== e_done || change !== 4'(e_chg)) begin
                n_fail++;
                $display("FAIL random[%0d]: got p=%0b d=%0b c=%0d want p=%0b d=%0b c=%0d",
                         i, product, done, change, e_prod, e_done, e_chg);
            end
            n_checks++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drink5();
        test_choc_1_2();
        test_select_switch();
        test_back_to_back();
        test_reset_mid();
        test_refund();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
